// File: rtl/pe_packet_injector.sv
// pe_packet_injector
//   Transmit-side network interface for a processing element. A start command
//   emits one packet into the router LOCAL port: a header flit (destination),
//   a size flit (payload count), then payload words prefetched from PE memory.
//   Flow control is credit based: a flit is accepted on an edge where
//   tx_o and credit_i are both high.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   start_i     in   command strobe, sampled only in IDLE
//   dest_i      in   header flit value
//   base_i      in   byte address of the first payload word
//   len_i       in   payload flit count (0 allowed)
//   busy_o      out  packet in progress (through the done cycle)
//   done_o      out  one-cycle pulse after the last flit is accepted
//   mem_rd_o    out  memory read request
//   mem_addr_o  out  memory read byte address
//   mem_data_i  in   read data, valid the cycle after mem_rd_o
//   tx_o        out  flit valid toward router
//   data_o      out  flit data
//   credit_i    in   router has buffer space
//   clock_tx_o  out  forwarded clock
module pe_packet_injector #(
  parameter int FLIT_WIDTH       = 32,
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH       = 13,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_i,
  input  logic [FLIT_WIDTH-1:0]       dest_i,
  input  logic [ADDR_WIDTH-1:0]       base_i,
  input  logic [LEN_WIDTH-1:0]        len_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        mem_rd_o,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_i,
  output logic                        tx_o,
  output logic [FLIT_WIDTH-1:0]       data_o,
  input  logic                        credit_i,
  output logic                        clock_tx_o
);

  typedef enum logic [2:0] {IDLE, HEADER, SIZE, PAYLOAD, FINISH} state_t;

  state_t                      state;
  logic [FLIT_WIDTH-1:0]       dest_q;
  logic [LEN_WIDTH-1:0]        len_q;
  logic [LEN_WIDTH-1:0]        issued;
  logic [LEN_WIDTH-1:0]        remaining;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [MEMORY_BUS_WIDTH-1:0] fifo [2];
  logic                        wr_ptr;
  logic                        rd_ptr;
  logic [1:0]                  count;
  logic                        in_flight;
  logic                        accept;
  logic                        pop;
  logic                        fetch_phase;
  logic [2:0]                  level;

  assign clock_tx_o = clock;
  assign mem_addr_o = addr_q;
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == FINISH);

  always_comb begin
    tx_o   = 1'b0;
    data_o = '0;
    case (state)
      HEADER: begin
        tx_o   = 1'b1;
        data_o = dest_q;
      end
      SIZE: begin
        tx_o   = 1'b1;
        data_o = FLIT_WIDTH'(len_q);
      end
      PAYLOAD: begin
        tx_o   = (count != 2'd0);
        data_o = FLIT_WIDTH'(fifo[rd_ptr]);
      end
      default: ;
    endcase
  end

  // Memory latency is exactly one cycle, so at most one read is in flight.
  // A new read is issued only if the words already owned (stored + in flight,
  // less the one leaving this cycle) leave a free FIFO slot for it.
  always_comb begin
    accept      = tx_o && credit_i;
    pop         = (state == PAYLOAD) && accept;
    fetch_phase = (state == HEADER) || (state == SIZE) || (state == PAYLOAD);
    level       = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
    mem_rd_o    = fetch_phase && (issued < len_q) && (level < 3'd2);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dest_q    <= '0;
      len_q     <= '0;
      issued    <= '0;
      remaining <= '0;
      addr_q    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
      in_flight <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) fifo[i] <= '0;
    end else begin
      in_flight <= mem_rd_o;
      if (mem_rd_o) begin
        addr_q <= addr_q + ADDR_WIDTH'(MEMORY_BUS_WIDTH / 8);
        issued <= issued + LEN_WIDTH'(1);
      end
      if (in_flight) begin
        fifo[wr_ptr] <= mem_data_i;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, in_flight} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (start_i) begin
            dest_q    <= dest_i;
            len_q     <= len_i;
            remaining <= len_i;
            addr_q    <= base_i;
            issued    <= '0;
            state     <= HEADER;
          end
        end
        HEADER: if (accept) state <= SIZE;
        SIZE: begin
          if (accept) state <= (len_q != '0) ? PAYLOAD : FINISH;
        end
        PAYLOAD: begin
          if (pop) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= FINISH;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_packet_injector.sv
module tb_pe_packet_injector;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] dest_i = '0;
  logic [12:0] base_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, mem_rd_o, tx_o, clock_tx_o;
  logic [12:0] mem_addr_o;
  logic [31:0] mem_data_i = '0;
  logic [31:0] data_o;
  logic        credit_i = 1'b0;

  pe_packet_injector #(
    .FLIT_WIDTH(32), .MEMORY_BUS_WIDTH(32), .ADDR_WIDTH(13), .LEN_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .start_i(start_i), .dest_i(dest_i),
    .base_i(base_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .tx_o(tx_o), .data_o(data_o), .credit_i(credit_i), .clock_tx_o(clock_tx_o)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // PE memory: word array, read data returned one cycle after the request.
  logic [31:0] mem [2048];
  always @(posedge clock) mem_data_i <= mem_rd_o ? mem[mem_addr_o[12:2]] : $urandom;

  // Credit generator: 0 = always 1, 1 = pattern 1,0,0 repeating, 2 = random.
  int cmode = 0;
  int ph = 0;
  always @(posedge clock) begin
    #1;
    case (cmode)
      0: credit_i = 1'b1;
      1: begin credit_i = (ph % 3 == 0); ph++; end
      default: credit_i = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: a packet is an ordered list of flits and read addresses.
  logic [31:0] exp_q [$];
  logic [12:0] adr_q [$];
  logic        mbusy = 0, done_pend = 0, prev_stall = 0, all_credit = 0;
  logic [31:0] prev_data = '0;
  int          iss = 0, pay_acc = 0, pkt_idx = 0, mstart = 0, mlen = 0, pkts_done = 0;
  // Logs of observed traffic, used by the directed literal checks.
  logic [31:0] acc_dat [$];
  int          acc_cyc [$];
  logic [12:0] rd_adr [$];
  int          done_cyc = 0;

  always @(negedge clock) begin
    logic acc, start_acc;
    logic [12:0] a;
    if (!reset) begin
      exp_q.delete(); adr_q.delete();
      mbusy = 0; done_pend = 0; prev_stall = 0; iss = 0; pay_acc = 0; pkt_idx = 0;
    end else begin
      chk("busy_o", busy_o, mbusy);
      chk("done_o", done_o, done_pend);
      if (!mbusy || done_pend) chk("tx_idle", tx_o, 0);
      if (prev_stall) begin
        chk("hold_tx", tx_o, 1);
        chk("hold_data", data_o, prev_data);
      end
      if (mem_rd_o) begin
        rd_adr.push_back(mem_addr_o);
        iss++;
        if (adr_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL extra_read: got addr %h expected no read", mem_addr_o);
        end else chk("mem_addr_o", mem_addr_o, adr_q.pop_front());
      end
      acc = tx_o && credit_i;
      if (acc) begin
        acc_dat.push_back(data_o);
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL extra_flit: got %h expected no flit", data_o);
        end else chk("data_o", data_o, exp_q.pop_front());
        if (pkt_idx >= 2) pay_acc++;
        pkt_idx++;
      end
      if (mem_rd_o) chk("outstanding_le2", 32'((iss - pay_acc) <= 2), 1);
      if (mbusy && !done_pend && !credit_i) all_credit = 0;
      prev_stall = tx_o && !credit_i;
      prev_data  = data_o;
      start_acc  = start_i && !mbusy;
      if (done_pend) begin
        done_cyc = cyc;
        chk("reads_left", adr_q.size(), 0);
        if (all_credit) chk("latency", cyc - mstart, mlen + 3);
        mbusy = 0;
        pkts_done++;
      end
      done_pend = acc && mbusy && (exp_q.size() == 0);
      if (start_acc) begin
        mbusy = 1; mstart = cyc; mlen = len_i; all_credit = 1;
        iss = 0; pay_acc = 0; pkt_idx = 0;
        exp_q.push_back(dest_i);
        exp_q.push_back({16'h0, len_i});
        for (int k = 0; k < int'(len_i); k++) begin
          a = base_i + 13'(k * 4);
          adr_q.push_back(a);
          exp_q.push_back(mem[a[12:2]]);
        end
      end
    end
  end

  int st_cyc = 0;

  task automatic clear_logs();
    acc_dat.delete(); acc_cyc.delete(); rd_adr.delete();
  endtask

  task automatic start_pkt(input logic [31:0] d, input logic [12:0] b, input logic [15:0] l);
    clear_logs();
    dest_i = d; base_i = b; len_i = l; start_i = 1'b1;
    st_cyc = cyc;
    @(posedge clock); #1;
    start_i = 1'b0; dest_i = $urandom; base_i = 13'($urandom); len_i = 16'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int n0;
    int t;
    n0 = pkts_done;
    t = 0;
    while (pkts_done == n0 && t < limit) begin @(posedge clock); #1; t++; end
    if (pkts_done == n0) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done_o expected within %0d cycles", limit);
    end
  endtask

  task automatic set_mode(input int m);
    cmode = m;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] e1 [5];
    int t;
    foreach (mem[i]) mem[i] = $urandom;
    mem[64] = 32'h1111_0001; mem[65] = 32'h1111_0002; mem[66] = 32'h1111_0003;
    mem[2047] = 32'h2222_0001; mem[0] = 32'h2222_0002;
    mem[192] = 32'hCAFE_0001;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_tx", tx_o, 0); chk("rst_data", data_o, 0); chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0); chk("rst_rd", mem_rd_o, 0); chk("rst_addr", mem_addr_o, 0);
    chk("clock_tx", clock_tx_o, clock);
    reset = 1'b1;
    set_mode(0);

    // len=3, base=0x100, full credit: exact flits, reads and timing
    start_pkt(32'h0000_0101, 13'h100, 16'd3);
    wait_done(50);
    e1 = '{32'h101, 32'h3, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
    chk("t1_count", acc_dat.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t1_flit", acc_dat[i], e1[i]);
      chk("t1_cycle", acc_cyc[i], st_cyc + 1 + i);
    end
    chk("t1_done_cycle", done_cyc, st_cyc + 6);
    chk("t1_reads", rd_adr.size(), 3);
    chk("t1_rd0", rd_adr[0], 13'h100); chk("t1_rd1", rd_adr[1], 13'h104);
    chk("t1_rd2", rd_adr[2], 13'h108);

    // len=0: header and size only, no reads
    start_pkt(32'hABCD_0012, 13'h040, 16'd0);
    wait_done(50);
    chk("t2_count", acc_dat.size(), 2);
    chk("t2_hdr", acc_dat[0], 32'hABCD_0012);
    chk("t2_size", acc_dat[1], 0);
    chk("t2_reads", rd_adr.size(), 0);
    chk("t2_done_cycle", done_cyc, st_cyc + 3);

    // len=4 with credit toggling 1,0,0
    set_mode(1);
    start_pkt(32'h0003_0002, 13'h400, 16'd4);
    wait_done(100);
    chk("t3_count", acc_dat.size(), 6);

    // address wrap
    set_mode(0);
    start_pkt(32'h0000_0001, 13'h1FFC, 16'd2);
    wait_done(50);
    chk("t4_reads", rd_adr.size(), 2);
    chk("t4_rd0", rd_adr[0], 13'h1FFC); chk("t4_rd1", rd_adr[1], 13'h0000);
    chk("t4_p0", acc_dat[2], 32'h2222_0001); chk("t4_p1", acc_dat[3], 32'h2222_0002);

    // start pulse during payload is ignored
    start_pkt(32'h0000_0505, 13'h800, 16'd8);
    t = 0;
    while (pay_acc < 2 && t < 100) begin @(posedge clock); #1; t++; end
    dest_i = 32'hDEAD_BEEF; base_i = 13'h10; len_i = 16'd1; start_i = 1'b1;
    @(posedge clock); #1;
    start_i = 1'b0;
    wait_done(100);
    chk("t5_count", acc_dat.size(), 10);
    chk("t5_hdr", acc_dat[0], 32'h505); chk("t5_size", acc_dat[1], 8);

    // reset after 2nd payload flit of len=8
    start_pkt(32'h0000_0202, 13'h200, 16'd8);
    t = 0;
    while (pay_acc < 2 && t < 100) begin @(posedge clock); #1; t++; end
    chk("t6_reached_payload", 32'(pay_acc >= 2), 1);
    reset = 1'b0;
    #1;
    chk("t6_tx", tx_o, 0); chk("t6_busy", busy_o, 0); chk("t6_rd", mem_rd_o, 0);
    chk("t6_done", done_o, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    start_pkt(32'h0000_0303, 13'h300, 16'd1);
    wait_done(50);
    chk("t6_count", acc_dat.size(), 3);
    chk("t6_hdr", acc_dat[0], 32'h303); chk("t6_size", acc_dat[1], 1);
    chk("t6_p0", acc_dat[2], 32'hCAFE_0001);
    chk("t6_reads", rd_adr.size(), 1);
    chk("t6_rd0", rd_adr[0], 13'h300);

    // randomized packets checked by the model
    for (int n = 0; n < 25; n++) begin
      cmode = $urandom_range(0, 2);
      start_pkt($urandom, {11'($urandom), 2'b00}, 16'($urandom_range(0, 12)));
      wait_done(300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
